// File: rtl/squid_round_ctrl_pkg.sv
// Shared types and helpers for the multi-player round controller.
package sqg_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INST  = 3'd1,
      GAME  = 3'd2,
      MODET = 3'd3,
      KILL  = 3'd4,
      END   = 3'd5
   } state_t;

   localparam logic [1:0] MUS_GAME = 2'b00;
   localparam logic [1:0] MUS_KILL = 2'b01;
   localparam logic [1:0] MUS_WIN  = 2'b10;
   localparam logic [1:0] MUS_DIE  = 2'b11;

   // Index of the lowest set bit; 0 when nothing is set.
   function automatic logic [2:0] lowest_set_index(input logic [7:0] v);
      lowest_set_index = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (v[i]) lowest_set_index = 3'(i);
   endfunction

endpackage

// File: rtl/squid_round_ctrl_sec_tick.sv
// Game-second prescaler: one-cycle tick every CLK_HZ cycles, restartable.
module sec_tick #(
   parameter int CLK_HZ = 25_000_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_reload,
   output logic o_tick
);

   localparam int            PW     = $clog2(CLK_HZ + 1);
   localparam logic [PW-1:0] RELOAD = PW'(CLK_HZ - 1);

   logic [PW-1:0] cnt;

   // Count down to zero, then wrap; a reload restarts a full second.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_reload || cnt == '0) cnt <= RELOAD;
      else                                cnt <= cnt - PW'(1);
   end

   assign o_tick = (cnt == '0);

endmodule

// File: rtl/squid_round_ctrl.sv
// Round flow controller: countdown, green/red light, kill and end screen
// for N_PLAYERS channels, with music triggers and turret angle latch.
module squid_round_ctrl
   import sqg_pkg::*;
#(
   parameter int CLK_HZ      = 25_000_000,
   parameter int N_PLAYERS   = 2,
   parameter int POS_W       = 3,
   parameter int INST_SEC    = 5,
   parameter int GAME_SEC    = 60,
   parameter int MODET_SEC   = 6,
   parameter int MUSIC_PULSE = 255
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_next,
   input  logic                       i_music_stop,
   input  logic [N_PLAYERS-1:0]       i_finish,
   input  logic [N_PLAYERS-1:0]       i_detect,
   input  logic [N_PLAYERS*POS_W-1:0] i_pos,
   output logic [2:0]                 o_state,
   output logic [6:0]                 o_deadline,
   output logic [3:0]                 o_sec_ten,
   output logic [3:0]                 o_sec_one,
   output logic [N_PLAYERS-1:0]       o_alive,
   output logic [N_PLAYERS-1:0]       o_won,
   output logic [POS_W-1:0]           o_angle,
   output logic                       o_angle_valid,
   output logic [1:0]                 o_music_ind,
   output logic                       o_play_music
);

   localparam int MW = $clog2(MUSIC_PULSE + 1);

   state_t                 state, state_nx;
   logic [6:0]             deadline, deadline_nx;
   logic [6:0]             det_cnt, det_nx;
   logic [N_PLAYERS-1:0]   alive, alive_nx, won, won_nx;
   logic [N_PLAYERS-1:0]   active, won_fin, act_fin, det_hit;
   logic [POS_W-1:0]       angle, angle_nx, hit_pos;
   logic [2:0]             hit_idx;
   logic [MW-1:0]          mus_cnt;
   logic                   tick, entering, reload, mus_load;

   assign active  = alive & ~won;
   // Finishing only counts for players still in the race.
   assign won_fin = won | (i_finish & active);
   assign act_fin = alive & ~won_fin;
   assign det_hit = i_detect & active;

   assign entering = (state_nx != state);
   assign reload   = entering && (state_nx inside {INST, GAME, MODET});
   assign mus_load = entering && (state_nx inside {GAME, KILL, END});

   sec_tick #(.CLK_HZ(CLK_HZ)) u_tick (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_reload (reload),
      .o_tick   (tick)
   );

   // Position of the lowest-index player caught moving.
   always_comb begin
      hit_pos = '0;
      hit_idx = lowest_set_index(8'(det_hit));
      for (int k = 0; k < N_PLAYERS; k++)
         if (3'(k) == hit_idx) hit_pos = i_pos[k*POS_W +: POS_W];
   end

   // Next-state and next datapath values for the round flow.
   always_comb begin
      state_nx    = state;
      deadline_nx = deadline;
      det_nx      = det_cnt;
      alive_nx    = alive;
      won_nx      = won;
      angle_nx    = angle;
      case (state)
         IDLE, END: begin
            if (i_next) begin
               state_nx    = INST;
               alive_nx    = '1;
               won_nx      = '0;
               deadline_nx = 7'(INST_SEC);
            end
         end
         INST: begin
            if (deadline == '0) begin
               state_nx    = GAME;
               deadline_nx = 7'(GAME_SEC);
            end else if (tick) begin
               deadline_nx = deadline - 7'd1;
            end
         end
         GAME: begin
            if (tick && deadline != '0) deadline_nx = deadline - 7'd1;
            if (i_music_stop) begin
               state_nx = MODET;
               det_nx   = 7'(MODET_SEC);
            end else begin
               // A finish in the last cycle still counts as a win.
               won_nx = won_fin;
               if (act_fin == '0) begin
                  state_nx = END;
               end else if (deadline == '0) begin
                  state_nx = END;
                  alive_nx = alive & ~act_fin;
               end
            end
         end
         MODET: begin
            if (tick && det_cnt != '0) det_nx = det_cnt - 7'd1;
            if (det_hit != '0) begin
               state_nx = KILL;
               alive_nx = alive & ~det_hit;
               angle_nx = hit_pos;
            end else if (det_cnt == '0) begin
               state_nx = GAME;
            end
         end
         KILL: begin
            if (i_music_stop) state_nx = (active != '0) ? GAME : END;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         deadline <= 7'(INST_SEC);
         det_cnt  <= 7'(MODET_SEC);
         alive    <= '1;
         won      <= '0;
         angle    <= '0;
         mus_cnt  <= '0;
      end else begin
         state    <= state_nx;
         deadline <= deadline_nx;
         det_cnt  <= det_nx;
         alive    <= alive_nx;
         won      <= won_nx;
         angle    <= angle_nx;
         if (mus_load)            mus_cnt <= MW'(MUSIC_PULSE);
         else if (mus_cnt != '0)  mus_cnt <= mus_cnt - MW'(1);
      end
   end

   // Song select follows the screen being shown.
   always_comb begin
      case (state)
         KILL:    o_music_ind = MUS_KILL;
         END:     o_music_ind = (won != '0) ? MUS_WIN : MUS_DIE;
         default: o_music_ind = MUS_GAME;
      endcase
   end

   assign o_state       = state;
   assign o_deadline    = deadline;
   assign o_sec_ten     = 4'(deadline / 7'd10);
   assign o_sec_one     = 4'(deadline % 7'd10);
   assign o_alive       = alive;
   assign o_won         = won;
   assign o_angle       = angle;
   assign o_angle_valid = (state == KILL);
   assign o_play_music  = (mus_cnt != '0);

endmodule

// File: tb/tb_squid_round_ctrl.sv
// Scoreboard bench for squid_round_ctrl: stimulus queues expected output
// values tagged with a cycle, a monitor pops and compares them.
module tb_squid_round_ctrl;

   localparam int NP = 2;
   localparam int PW = 3;

   localparam int S_STATE = 0, S_DL = 1, S_TEN = 2, S_ONE = 3, S_ALIVE = 4,
                  S_WON = 5, S_ANG = 6, S_AV = 7, S_MIND = 8, S_PLAY = 9;

   logic            clk = 1'b0;
   logic            i_rst, i_next, i_music_stop;
   logic [NP-1:0]   i_finish, i_detect;
   logic [NP*PW-1:0] i_pos;
   logic [2:0]      o_state;
   logic [6:0]      o_deadline;
   logic [3:0]      o_sec_ten, o_sec_one;
   logic [NP-1:0]   o_alive, o_won;
   logic [PW-1:0]   o_angle;
   logic            o_angle_valid, o_play_music;
   logic [1:0]      o_music_ind;

   squid_round_ctrl #(
      .CLK_HZ(4), .N_PLAYERS(NP), .POS_W(PW), .INST_SEC(2),
      .GAME_SEC(3), .MODET_SEC(2), .MUSIC_PULSE(5)
   ) dut (
      .i_clk(clk), .i_rst(i_rst), .i_next(i_next), .i_music_stop(i_music_stop),
      .i_finish(i_finish), .i_detect(i_detect), .i_pos(i_pos),
      .o_state(o_state), .o_deadline(o_deadline), .o_sec_ten(o_sec_ten),
      .o_sec_one(o_sec_one), .o_alive(o_alive), .o_won(o_won), .o_angle(o_angle),
      .o_angle_valid(o_angle_valid), .o_music_ind(o_music_ind),
      .o_play_music(o_play_music)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int    cyc;
      int    sel;
      int    val;
      string name;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic int act(input int sel);
      case (sel)
         S_STATE: act = int'(o_state);
         S_DL:    act = int'(o_deadline);
         S_TEN:   act = int'(o_sec_ten);
         S_ONE:   act = int'(o_sec_one);
         S_ALIVE: act = int'(o_alive);
         S_WON:   act = int'(o_won);
         S_ANG:   act = int'(o_angle);
         S_AV:    act = int'(o_angle_valid);
         S_MIND:  act = int'(o_music_ind);
         S_PLAY:  act = int'(o_play_music);
         default: act = -1;
      endcase
   endfunction

   // Monitor: compare every expectation due in this cycle, away from the edge.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         n_checks++;
         if (e.cyc != cyc) begin
            n_fail++;
            $display("FAIL %s: check missed its cycle (due %0d, now %0d)", e.name, e.cyc, cyc);
         end else if (act(e.sel) != e.val) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, act(e.sel), e.val, cyc);
         end
      end
   end

   task automatic chk(input int sel, input int val, input string name);
      exp_t x;
      x.cyc = cyc; x.sel = sel; x.val = val; x.name = name;
      q.push_back(x);
   endtask

   task automatic tick1();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick1();
   endtask

   // From IDLE/END: start a round and run through the 9-cycle countdown.
   task automatic start_to_game();
      i_next = 1'b1; tick1(); i_next = 1'b0;
      ticks(9);
   endtask

   task automatic pulse_stop();
      i_music_stop = 1'b1; tick1(); i_music_stop = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      i_rst = 1'b1; i_next = 1'b0; i_music_stop = 1'b0;
      i_finish = '0; i_detect = '0; i_pos = '0;
      ticks(2);
      chk(S_STATE, 0, "rst_state");   chk(S_DL, 2, "rst_deadline");
      chk(S_ALIVE, 3, "rst_alive");   chk(S_WON, 0, "rst_won");
      chk(S_ANG, 0, "rst_angle");     chk(S_AV, 0, "rst_angle_valid");
      chk(S_PLAY, 0, "rst_play");     chk(S_MIND, 0, "rst_music_ind");
      i_rst = 1'b0;
      tick1();
      chk(S_STATE, 0, "idle_hold");

      // 1: countdown and entry into GAME
      i_next = 1'b1; tick1(); i_next = 1'b0;
      chk(S_STATE, 1, "t1_inst");     chk(S_DL, 2, "t1_inst_dl");
      ticks(7);
      chk(S_DL, 1, "t1_inst_c7_dl");
      tick1();
      chk(S_STATE, 1, "t1_inst_c8");  chk(S_DL, 0, "t1_inst_c8_dl");
      tick1();
      chk(S_STATE, 2, "t1_game");     chk(S_DL, 3, "t1_game_dl");
      chk(S_ONE, 3, "t1_sec_one");    chk(S_TEN, 0, "t1_sec_ten");
      for (int i = 0; i < 6; i++) begin
         chk(S_PLAY, (i < 5) ? 1 : 0, "t1_play_window");
         tick1();
      end

      // 2: deadline runs out with nobody finishing
      chk(S_DL, 2, "t2_dl_c6");
      ticks(6);
      chk(S_STATE, 2, "t2_game_c12"); chk(S_DL, 0, "t2_dl_zero");
      tick1();
      chk(S_STATE, 5, "t2_end");      chk(S_ALIVE, 0, "t2_alive");
      chk(S_WON, 0, "t2_won");        chk(S_MIND, 3, "t2_music_die");
      chk(S_PLAY, 1, "t2_play");

      // 3: both players finish
      i_next = 1'b1; tick1(); i_next = 1'b0;
      chk(S_STATE, 1, "t3_restart");  chk(S_ALIVE, 3, "t3_alive_init");
      chk(S_DL, 2, "t3_dl_init");
      ticks(9);
      chk(S_STATE, 2, "t3_game");
      tick1();
      i_finish = 2'b01; tick1(); i_finish = '0;
      chk(S_WON, 1, "t3_won0");       chk(S_STATE, 2, "t3_still_game");
      i_finish = 2'b10; tick1(); i_finish = '0;
      chk(S_STATE, 5, "t3_end");      chk(S_WON, 3, "t3_won_all");
      chk(S_ALIVE, 3, "t3_alive");    chk(S_MIND, 2, "t3_music_win");

      // 3b: finish in the deadline==0 cycle counts
      start_to_game();
      i_finish = 2'b01; tick1(); i_finish = '0;
      chk(S_WON, 1, "t3b_won0");
      ticks(11);
      chk(S_DL, 0, "t3b_dl_zero");    chk(S_STATE, 2, "t3b_game_c12");
      i_finish = 2'b10; tick1(); i_finish = '0;
      chk(S_STATE, 5, "t3b_end");     chk(S_WON, 3, "t3b_won_all");
      chk(S_ALIVE, 3, "t3b_alive");   chk(S_MIND, 2, "t3b_music_win");

      // 4: red light, player 1 caught
      start_to_game();
      tick1();
      pulse_stop();
      chk(S_STATE, 3, "t4_modet");    chk(S_DL, 3, "t4_modet_dl");
      i_pos = {3'd5, 3'd3}; i_detect = 2'b10; tick1(); i_detect = '0;
      chk(S_STATE, 4, "t4_kill");     chk(S_ANG, 5, "t4_angle");
      chk(S_AV, 1, "t4_angle_valid"); chk(S_ALIVE, 1, "t4_alive");
      chk(S_MIND, 1, "t4_music_kill"); chk(S_DL, 3, "t4_kill_dl");
      tick1();
      chk(S_STATE, 4, "t4_kill_hold"); chk(S_ANG, 5, "t4_angle_hold");
      pulse_stop();
      chk(S_STATE, 2, "t4_back_game"); chk(S_DL, 3, "t4_dl_unchanged");
      chk(S_ANG, 5, "t4_angle_kept"); chk(S_AV, 0, "t4_angle_invalid");
      chk(S_MIND, 0, "t4_music_game");
      i_finish = 2'b10; tick1(); i_finish = '0;
      chk(S_WON, 0, "t4_dead_finish_ignored"); chk(S_STATE, 2, "t4_game_stay");

      // 6a: detect window expires; dead player motion and i_next ignored
      pulse_stop();
      chk(S_STATE, 3, "t6_modet");
      ticks(2);
      i_detect = 2'b10; i_next = 1'b1; tick1(); i_detect = '0; i_next = 1'b0;
      chk(S_STATE, 3, "t6_dead_detect_ignored"); chk(S_ALIVE, 1, "t6_alive");
      ticks(5);
      chk(S_STATE, 3, "t6_modet_c8");
      tick1();
      chk(S_STATE, 2, "t6_expired_game"); chk(S_DL, 3, "t6_dl_frozen");

      // 6b: detect in the expiry cycle wins, then reset during KILL
      tick1();
      pulse_stop();
      ticks(8);
      i_pos = {3'd0, 3'd4}; i_detect = 2'b01; tick1(); i_detect = '0;
      chk(S_STATE, 4, "t6_expiry_kill"); chk(S_ANG, 4, "t6_angle");
      chk(S_ALIVE, 0, "t6_alive_none");
      i_rst = 1'b1; tick1(); i_rst = 1'b0;
      chk(S_STATE, 0, "t6_rst_idle");  chk(S_ANG, 0, "t6_rst_angle");
      chk(S_ALIVE, 3, "t6_rst_alive"); chk(S_AV, 0, "t6_rst_av");
      chk(S_DL, 2, "t6_rst_dl");       chk(S_PLAY, 0, "t6_rst_play");

      // 5: both caught at once, lowest index sets the angle
      start_to_game();
      tick1();
      pulse_stop();
      i_pos = {3'd6, 3'd2}; i_detect = 2'b11; tick1(); i_detect = '0;
      chk(S_STATE, 4, "t5_kill");      chk(S_ANG, 2, "t5_angle_lowest");
      chk(S_ALIVE, 0, "t5_alive");
      pulse_stop();
      chk(S_STATE, 5, "t5_end");       chk(S_MIND, 3, "t5_music_die");
      chk(S_ANG, 2, "t5_angle_kept");  chk(S_AV, 0, "t5_angle_invalid");

      for (int i = 0; i < 10 && q.size() > 0; i++) tick1();
      if (q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations never checked, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
